sum_accumulator: RTL and testbench

- Downstream stage of the adder consumer: takes the per-cycle sums it produces and accumulates frames of N_BEATS beats into one 32-bit signed total, with a valid/ready handshake on both sides.
- Each accumulation step is performed by calling the interface-provided task adder through an I.P1 modport port, inside combinational logic.
- The result is held until the downstream side takes it.

---
 rtl/acc_pkg.sv | 18 +
 rtl/I.sv | 10 +
 rtl/acc_sat_unit.sv | 23 ++
 rtl/sum_accumulator.sv | 133 +++++++++++++
 tb/tb_sum_accumulator.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// Shared types, limits and sizing helpers for the frame accumulator.
package acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  localparam logic signed [31:0] ACC_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] ACC_MIN = 32'sh8000_0000;

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/I.sv
// Adder service interface: the accumulation step is taken from here.
interface I;

  task automatic adder(input int i_a, input int i_b, output int o_a);
    o_a = i_a + i_b;
  endtask

  modport P1 (import adder);

endinterface

// File: rtl/acc_sat_unit.sv
// Signed-overflow detection with optional saturation of a 32-bit sum.
module acc_sat_unit
  import acc_pkg::*;
#(
  parameter int SAT = 1
) (
  input  logic signed [31:0] base,
  input  logic signed [31:0] i_sum,
  input  logic signed [31:0] raw,
  output logic signed [31:0] next_acc,
  output logic               ovf
);

  // Overflow when both operands share a sign that the raw sum lost.
  always_comb begin
    ovf      = (base[31] == i_sum[31]) && (raw[31] != base[31]);
    next_acc = raw;
    if (ovf && (SAT != 0)) begin
      next_acc = base[31] ? ACC_MIN : ACC_MAX;
    end
  end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates frames of N_BEATS signed sums into one 32-bit total and
// holds the result until the downstream side takes it.
module sum_accumulator
  import acc_pkg::*;
#(
  parameter int N_BEATS = 4,
  parameter int SAT     = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  I.P1                                  p1,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic signed [31:0]            i_sum,
  input  logic                          i_flush,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic signed [31:0]            o_acc,
  output logic                          o_ovf,
  output logic [cnt_w(N_BEATS)-1:0]     o_count
);

  localparam int               CNT_W = cnt_w(N_BEATS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_BEATS);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  if (N_BEATS < 1) begin : g_bad_n_beats
    $error("sum_accumulator: N_BEATS must be >= 1");
  end

  state_t                state_q, state_d;
  logic signed [31:0]    acc_q, acc_d;
  logic signed [31:0]    base, raw, sat_next, step_acc;
  logic                  ovf_q, ovf_d, beat_ovf;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                  accept;

  // Beat operand: running total inside a frame, zero when a frame starts.
  always_comb begin
    base = (state_q == ACCUM) ? acc_q : '0;
    raw  = '0;
    p1.adder(base, i_sum, raw);
  end

  acc_sat_unit #(
    .SAT (SAT)
  ) u_sat (
    .base     (base),
    .i_sum    (i_sum),
    .raw      (raw),
    .next_acc (sat_next),
    .ovf      (beat_ovf)
  );

  // Once a saturating frame has overflowed, the clamped total is frozen.
  always_comb begin
    step_acc = sat_next;
    if ((SAT != 0) && ovf_q) begin
      step_acc = acc_q;
    end
  end

  // State register and frame datapath, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: flush wins, HOLD restarts a frame when the result leaves.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + ONE;
    accept  = i_valid && o_ready;
    if (i_flush) begin
      state_d = IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (accept) begin
            state_d = (N_BEATS == 1) ? HOLD : ACCUM;
            acc_d   = sat_next;
            ovf_d   = beat_ovf;
            cnt_d   = ONE;
          end else if ((state_q == HOLD) && i_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_d = step_acc;
            ovf_d = ovf_q || beat_ovf;
            cnt_d = cnt_inc;
            if (cnt_inc == LAST) begin
              state_d = HOLD;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake outputs; a held result passes ready straight through.
  always_comb begin
    o_valid = (state_q == HOLD);
    o_ready = 1'b0;
    if (i_rst_n && !i_flush) begin
      o_ready = (state_q == HOLD) ? i_ready : 1'b1;
    end
    o_acc   = acc_q;
    o_ovf   = ovf_q;
    o_count = cnt_q;
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: table vectors, corner sequences and random
// traffic against a frame-level reference model, on three configurations.
module tb_sum_accumulator;

  logic clk;
  logic rst_n;
  logic v, fl, rdy;
  logic signed [31:0] s;

  logic               rdy_a, vld_a, ovf_a;
  logic signed [31:0] acc_a;
  logic [2:0]         cnt_a;
  logic               rdy_b, vld_b, ovf_b;
  logic signed [31:0] acc_b;
  logic [2:0]         cnt_b;
  logic               rdy_c, vld_c, ovf_c;
  logic signed [31:0] acc_c;
  logic [0:0]         cnt_c;

  int checks = 0;
  int errors = 0;

  I if_a ();
  I if_b ();
  I if_c ();

  sum_accumulator #(.N_BEATS(4), .SAT(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .p1(if_a), .i_valid(v), .o_ready(rdy_a),
    .i_sum(s), .i_flush(fl), .o_valid(vld_a), .i_ready(rdy), .o_acc(acc_a),
    .o_ovf(ovf_a), .o_count(cnt_a));

  sum_accumulator #(.N_BEATS(4), .SAT(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .p1(if_b), .i_valid(v), .o_ready(rdy_b),
    .i_sum(s), .i_flush(fl), .o_valid(vld_b), .i_ready(rdy), .o_acc(acc_b),
    .o_ovf(ovf_b), .o_count(cnt_b));

  sum_accumulator #(.N_BEATS(1), .SAT(1)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .p1(if_c), .i_valid(v), .o_ready(rdy_c),
    .i_sum(s), .i_flush(fl), .o_valid(vld_c), .i_ready(rdy), .o_acc(acc_c),
    .o_ovf(ovf_c), .o_count(cnt_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level reference: beats in the open frame, total, sticky overflow,
  // and whether a finished result is waiting for the consumer.
  typedef struct {
    int n;
    bit sat;
    bit pend;
    int cnt;
    int acc;
    bit ovf;
  } mdl_t;

  mdl_t ma, mb, mc;

  function automatic void mclear(inout mdl_t m);
    m.pend = 1'b0;
    m.cnt  = 0;
    m.acc  = 0;
    m.ovf  = 1'b0;
  endfunction

  function automatic void step(inout mdl_t m, input bit iv, input int is,
                               input bit ifl, input bit ir);
    bit     take;
    longint t;
    if (ifl) begin
      mclear(m);
      return;
    end
    take = iv && (!m.pend || ir);
    if (m.pend && ir) mclear(m);
    if (take) begin
      t = longint'(m.acc) + longint'(is);
      if (!(m.sat && m.ovf)) begin
        if (t > 64'sd2147483647 || t < -64'sd2147483648) begin
          m.ovf = 1'b1;
          if (m.sat) m.acc = (t > 0) ? 32'sh7FFF_FFFF : 32'sh8000_0000;
          else       m.acc = int'(t);
        end else begin
          m.acc = int'(t);
        end
      end
      m.cnt = m.cnt + 1;
      if (m.cnt == m.n) m.pend = 1'b1;
    end
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic mchk(input string t, input mdl_t m, input logic ar,
                      input logic av, input int aa, input logic ao, input int ac);
    chk({t, " o_ready"}, longint'(ar), longint'(!fl && (!m.pend || rdy)));
    chk({t, " o_valid"}, longint'(av), longint'(m.pend));
    chk({t, " o_acc"},   longint'(aa), longint'(m.acc));
    chk({t, " o_ovf"},   longint'(ao), longint'(m.ovf));
    chk({t, " o_count"}, longint'(ac), longint'(m.cnt));
  endtask

  // Apply inputs, then compare all three DUTs to the model at the falling edge.
  task automatic drive(input bit iv, input int is, input bit ifl, input bit ir);
    v   = iv;
    s   = is;
    fl  = ifl;
    rdy = ir;
    @(negedge clk);
    mchk("A", ma, rdy_a, vld_a, acc_a, ovf_a, int'(cnt_a));
    mchk("B", mb, rdy_b, vld_b, acc_b, ovf_b, int'(cnt_b));
    mchk("C", mc, rdy_c, vld_c, acc_c, ovf_c, int'(cnt_c));
  endtask

  task automatic adv();
    step(ma, v, s, fl, rdy);
    step(mb, v, s, fl, rdy);
    step(mc, v, s, fl, rdy);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit v; int s; bit fl; bit r;
    bit e_rdy; bit e_vld; int e_acc; int e_accb; bit e_ovf; int e_cnt;
  } row_t;

  row_t tbl[64];
  int   nrows = 0;

  task automatic add(input bit iv, input int is, input bit ifl, input bit ir,
                     input bit erdy, input bit evld, input int eacc,
                     input int eaccb, input bit eovf, input int ecnt);
    tbl[nrows] = '{iv, is, ifl, ir, erdy, evld, eacc, eaccb, eovf, ecnt};
    nrows++;
  endtask

  initial begin
    int rs;
    ma = '{4, 1'b1, 1'b0, 0, 0, 1'b0};
    mb = '{4, 1'b0, 1'b0, 0, 0, 1'b0};
    mc = '{1, 1'b1, 1'b0, 0, 0, 1'b0};

    // Frame 1,2,3,4 with consumer ready; result visible exactly one cycle.
    add(1, 1, 0, 1,  1, 0, 0, 0, 0, 0);
    add(1, 2, 0, 1,  1, 0, 1, 1, 0, 1);
    add(1, 3, 0, 1,  1, 0, 3, 3, 0, 2);
    add(1, 4, 0, 1,  1, 0, 6, 6, 0, 3);
    add(0, 0, 0, 1,  1, 1, 10, 10, 0, 4);
    add(0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
    // Positive overflow: A saturates and freezes, B wraps.
    add(1, 32'sh7FFF_FFF0, 0, 1,  1, 0, 0, 0, 0, 0);
    add(1, 32'sh0000_0020, 0, 1,  1, 0, 32'sh7FFF_FFF0, 32'sh7FFF_FFF0, 0, 1);
    add(1, 5, 0, 1,   1, 0, 32'sh7FFF_FFFF, 32'sh8000_0010, 1, 2);
    add(1, -3, 0, 1,  1, 0, 32'sh7FFF_FFFF, 32'sh8000_0015, 1, 3);
    add(0, 0, 0, 1,   1, 1, 32'sh7FFF_FFFF, 32'sh8000_0012, 1, 4);
    add(0, 0, 0, 1,   1, 0, 0, 0, 0, 0);
    // Result stalled by the consumer while beat 7 waits, then overlap.
    add(1, 1, 0, 0,  1, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0,  1, 0, 1, 1, 0, 1);
    add(1, 3, 0, 0,  1, 0, 3, 3, 0, 2);
    add(1, 4, 0, 0,  1, 0, 6, 6, 0, 3);
    for (int k = 0; k < 5; k++) add(1, 7, 0, 0,  0, 1, 10, 10, 0, 4);
    add(1, 7, 0, 1,  1, 1, 10, 10, 0, 4);
    add(1, 1, 0, 1,  1, 0, 7, 7, 0, 1);
    add(1, 2, 0, 1,  1, 0, 8, 8, 0, 2);
    add(1, 3, 0, 1,  1, 0, 10, 10, 0, 3);
    add(0, 0, 0, 1,  1, 1, 13, 13, 0, 4);
    // Flush after two beats drops the frame and the beat beside it.
    add(1, 5, 0, 1,  1, 0, 0, 0, 0, 0);
    add(1, 6, 0, 1,  1, 0, 5, 5, 0, 1);
    add(1, 9, 1, 1,  0, 0, 11, 11, 0, 2);
    add(1, 1, 0, 1,  1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1,  1, 0, 1, 1, 0, 1);
    add(1, 1, 0, 1,  1, 0, 2, 2, 0, 2);
    add(1, 1, 0, 1,  1, 0, 3, 3, 0, 3);
    add(0, 0, 0, 1,  1, 1, 4, 4, 0, 4);
    // Flush discards a result held in HOLD.
    add(1, 1, 0, 0,  1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0,  1, 0, 1, 1, 0, 1);
    add(1, 1, 0, 0,  1, 0, 2, 2, 0, 2);
    add(1, 1, 0, 0,  1, 0, 3, 3, 0, 3);
    add(0, 0, 0, 0,  0, 1, 4, 4, 0, 4);
    add(1, 5, 1, 0,  0, 1, 4, 4, 0, 4);
    add(0, 0, 0, 0,  1, 0, 0, 0, 0, 0);

    v = 1'b0; s = '0; fl = 1'b0; rdy = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("reset o_valid", longint'(vld_a), 0);
    chk("reset o_ready", longint'(rdy_a), 0);
    chk("reset o_count", longint'(cnt_a), 0);
    chk("reset o_acc",   longint'(acc_a), 0);
    #6;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < nrows; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].fl, tbl[i].r);
      chk($sformatf("row%0d o_ready", i), longint'(rdy_a), longint'(tbl[i].e_rdy));
      chk($sformatf("row%0d o_valid", i), longint'(vld_a), longint'(tbl[i].e_vld));
      chk($sformatf("row%0d o_acc", i),   longint'(acc_a), longint'(tbl[i].e_acc));
      chk($sformatf("row%0d o_acc_wrap", i), longint'(acc_b), longint'(tbl[i].e_accb));
      chk($sformatf("row%0d o_ovf", i),   longint'(ovf_a), longint'(tbl[i].e_ovf));
      chk($sformatf("row%0d o_count", i), longint'(cnt_a), longint'(tbl[i].e_cnt));
      adv();
    end

    // Asynchronous reset in the middle of a frame holding 9.
    drive(1, 4, 0, 1); adv();
    drive(1, 5, 0, 1); adv();
    chk("pre-reset o_acc", longint'(acc_a), 9);
    #2;
    v = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset o_valid", longint'(vld_a), 0);
    chk("midreset o_ready", longint'(rdy_a), 0);
    chk("midreset o_count", longint'(cnt_a), 0);
    mclear(ma); mclear(mb); mclear(mc);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      drive(1, 2, 0, 1); adv();
    end
    drive(0, 0, 0, 1);
    chk("after-reset o_valid", longint'(vld_a), 1);
    chk("after-reset o_acc",   longint'(acc_a), 8);
    adv();

    // Single-beat frames streaming back to back.
    drive(1, -3, 0, 1);
    chk("n1 ready0", longint'(rdy_c), 1);
    adv();
    drive(1, 4, 0, 1);
    chk("n1 acc1", longint'(acc_c), -3);
    chk("n1 valid1", longint'(vld_c), 1);
    chk("n1 ready1", longint'(rdy_c), 1);
    adv();
    drive(1, -5, 0, 1);
    chk("n1 acc2", longint'(acc_c), 4);
    chk("n1 valid2", longint'(vld_c), 1);
    chk("n1 ready2", longint'(rdy_c), 1);
    adv();
    drive(0, 0, 0, 1);
    chk("n1 acc3", longint'(acc_c), -5);
    chk("n1 valid3", longint'(vld_c), 1);
    adv();
    drive(0, 0, 1, 1); adv();

    // Random traffic including values near the signed limits.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       rs = int'($urandom);
        1:       rs = int'(32'h7FFF_FFF0 + $urandom_range(0, 15));
        2:       rs = int'(32'h8000_0000 + $urandom_range(0, 15));
        default: rs = int'($urandom_range(0, 200)) - 100;
      endcase
      drive(($urandom_range(0, 9) < 7), rs, ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 9) < 6));
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
